// File: rtl/data_demux.sv
// One-to-five packet demultiplexer with a single registered output stage.
// Define DATA_DEMUX_ERR_EN to drop packets with out-of-range sel and pulse err.
module data_demux #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             din_last,
  output logic             din_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_last,
  output logic [4:0]       dout_valid,
  input  logic [4:0]       dout_ready
`ifdef DATA_DEMUX_ERR_EN
  ,
  output logic             err
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1
`ifdef DATA_DEMUX_ERR_EN
    ,
    DROP  = 2'd2
`endif
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [2:0]       ch_r;
  logic [2:0]       ch_s;
  logic             en_r;
  logic             accept_s;
  logic             drain_s;
  logic             route_s;
  logic [2:0]       route_ch_s;
  logic             din_ready_s;
  logic [WIDTH-1:0] dout_r;
  logic             dout_last_r;
  logic [4:0]       dout_valid_r;
`ifdef DATA_DEMUX_ERR_EN
  logic             err_s;
  logic             err_r;
`endif

  function automatic logic [4:0] onehot5(input logic [2:0] c);
    logic [4:0] v;
    case (c)
      3'd0:    v = 5'b00001;
      3'd1:    v = 5'b00010;
      3'd2:    v = 5'b00100;
      3'd3:    v = 5'b01000;
      3'd4:    v = 5'b10000;
      default: v = 5'b00000;
    endcase
    return v;
  endfunction

  // Only the addressed consumer's ready can drain the held beat.
  assign drain_s = |(dout_valid_r & dout_ready);

  // Input handshake: blocked during reset and the cycle it releases.
  always_comb begin
    din_ready_s = en_r & (~(|dout_valid_r) | drain_s);
`ifdef DATA_DEMUX_ERR_EN
    if (state_r == DROP) begin
      din_ready_s = en_r;
    end else begin
      din_ready_s = en_r & (~(|dout_valid_r) | drain_s);
    end
`endif
  end

  assign din_ready = din_ready_s;
  assign accept_s  = din_valid & din_ready_s;

  // Next-state, channel latch and routing decision.
  always_comb begin
    state_s    = state_r;
    ch_s       = ch_r;
    route_s    = 1'b0;
    route_ch_s = ch_r;
`ifdef DATA_DEMUX_ERR_EN
    err_s      = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (accept_s && (sel <= 3'd4)) begin
          ch_s       = sel;
          route_s    = 1'b1;
          route_ch_s = sel;
          state_s    = din_last ? IDLE : ROUTE;
        end else if (accept_s) begin
`ifdef DATA_DEMUX_ERR_EN
          err_s      = 1'b1;
          state_s    = din_last ? IDLE : DROP;
`else
          ch_s       = 3'd0;
          route_s    = 1'b1;
          route_ch_s = 3'd0;
          state_s    = din_last ? IDLE : ROUTE;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      ROUTE: begin
        if (accept_s) begin
          route_s = 1'b1;
          state_s = din_last ? IDLE : ROUTE;
        end else begin
          state_s = ROUTE;
        end
      end
`ifdef DATA_DEMUX_ERR_EN
      DROP: begin
        if (accept_s && din_last) begin
          state_s = IDLE;
        end else begin
          state_s = DROP;
        end
      end
`endif
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ch_r    <= 3'd0;
      en_r    <= 1'b0;
`ifdef DATA_DEMUX_ERR_EN
      err_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      ch_r    <= ch_s;
      en_r    <= 1'b1;
`ifdef DATA_DEMUX_ERR_EN
      err_r   <= err_s;
`endif
    end
  end

  // Output register: load overrides drain so full throughput is sustained.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_r       <= {WIDTH{1'b0}};
      dout_last_r  <= 1'b0;
      dout_valid_r <= 5'b00000;
    end else if (route_s) begin
      dout_r       <= din;
      dout_last_r  <= din_last;
      dout_valid_r <= onehot5(route_ch_s);
    end else if (drain_s) begin
      dout_valid_r <= 5'b00000;
    end else begin
      dout_valid_r <= dout_valid_r;
    end
  end

  assign dout       = dout_r;
  assign dout_last  = dout_last_r;
  assign dout_valid = dout_valid_r;
`ifdef DATA_DEMUX_ERR_EN
  assign err        = err_r;
`endif

endmodule

// File: tb/tb_data_demux.sv
// Directed self-checking bench for data_demux (default and DATA_DEMUX_ERR_EN builds).
module tb_data_demux;

  logic        clk;
  logic        rst_n;
  logic [2:0]  sel;
  logic [15:0] din;
  logic        din_valid;
  logic        din_last;
  logic        din_ready;
  logic [15:0] dout;
  logic        dout_last;
  logic [4:0]  dout_valid;
  logic [4:0]  dout_ready;
`ifdef DATA_DEMUX_ERR_EN
  logic        err;
`endif

  int compared   = 0;
  int mismatched = 0;

  data_demux #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sel        (sel),
    .din        (din),
    .din_valid  (din_valid),
    .din_last   (din_last),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_last  (dout_last),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
`ifdef DATA_DEMUX_ERR_EN
    ,
    .err        (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [2:0] s, input logic [15:0] d, input logic l);
    sel       = s;
    din       = d;
    din_last  = l;
    din_valid = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    sel        = 3'd0;
    din        = 16'h0000;
    din_valid  = 1'b0;
    din_last   = 1'b0;
    dout_ready = 5'b11111;

    // Reset state
    #2;
    check("rst_dout_valid", {27'd0, dout_valid}, 32'd0);
    check("rst_dout", {16'd0, dout}, 32'd0);
    check("rst_dout_last", {31'd0, dout_last}, 32'd0);
    check("rst_din_ready", {31'd0, din_ready}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("release_ready_low", {31'd0, din_ready}, 32'd0);
    tick();
    check("release_ready_high", {31'd0, din_ready}, 32'd1);

    // Single beat to channel 3
    beat(3'd3, 16'hA5A5, 1'b1);
    tick();
    din_valid = 1'b0;
    check("single_valid", {27'd0, dout_valid}, 32'h08);
    check("single_dout", {16'd0, dout}, 32'hA5A5);
    check("single_last", {31'd0, dout_last}, 32'd1);
    tick();
    check("single_drained", {27'd0, dout_valid}, 32'd0);

    // Channel stickiness: sel changes after beat 0 are ignored
    for (int k = 1; k <= 4; k++) begin
      beat((k == 1) ? 3'd2 : 3'd4, 16'(k), (k == 4));
      tick();
      check("sticky_valid", {27'd0, dout_valid}, 32'h04);
      check("sticky_dout", {16'd0, dout}, 32'(k));
      check("sticky_last", {31'd0, dout_last}, (k == 4) ? 32'd1 : 32'd0);
    end
    din_valid = 1'b0;
    tick();
    check("sticky_drained", {27'd0, dout_valid}, 32'd0);

    // Backpressure on channel 1; other readies high must not drain it
    dout_ready = 5'b11101;
    beat(3'd1, 16'h0010, 1'b0);
    #1;
    check("bp_ready_empty", {31'd0, din_ready}, 32'd1);
    tick();
    check("bp_first_valid", {27'd0, dout_valid}, 32'h02);
    beat(3'd1, 16'h0011, 1'b0);
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_ready_low", {31'd0, din_ready}, 32'd0);
      tick();
      check("bp_hold_dout", {16'd0, dout}, 32'h0010);
      check("bp_hold_valid", {27'd0, dout_valid}, 32'h02);
    end
    dout_ready = 5'b11111;
    #1;
    check("bp_ready_resume", {31'd0, din_ready}, 32'd1);
    for (int k = 16'h11; k <= 16'h15; k++) begin
      beat(3'd1, 16'(k), (k == 16'h15));
      tick();
      check("bp_stream_dout", {16'd0, dout}, 32'(k));
      check("bp_stream_valid", {27'd0, dout_valid}, 32'h02);
    end
    din_valid = 1'b0;
    tick();
    check("bp_drained", {27'd0, dout_valid}, 32'd0);

    // Back-to-back packets: ch0 single beat then 2-beat ch4
    beat(3'd0, 16'h0100, 1'b1);
    tick();
    check("b2b_0_valid", {27'd0, dout_valid}, 32'h01);
    check("b2b_0_last", {31'd0, dout_last}, 32'd1);
    beat(3'd4, 16'h0200, 1'b0);
    tick();
    check("b2b_1_valid", {27'd0, dout_valid}, 32'h10);
    check("b2b_1_dout", {16'd0, dout}, 32'h0200);
    beat(3'd1, 16'h0201, 1'b1);
    tick();
    check("b2b_2_valid", {27'd0, dout_valid}, 32'h10);
    check("b2b_2_dout", {16'd0, dout}, 32'h0201);
    check("b2b_2_last", {31'd0, dout_last}, 32'd1);
    din_valid = 1'b0;
    tick();

    // Out-of-range sel on a 3-beat packet
    for (int k = 0; k < 3; k++) begin
      beat(3'd6, 16'(16'h0300 + k), (k == 2));
      #1;
      check("oor_ready", {31'd0, din_ready}, 32'd1);
      tick();
`ifdef DATA_DEMUX_ERR_EN
      check("oor_no_valid", {27'd0, dout_valid}, 32'd0);
      check("oor_err", {31'd0, err}, (k == 0) ? 32'd1 : 32'd0);
`else
      check("oor_valid_ch0", {27'd0, dout_valid}, 32'h01);
      check("oor_dout", {16'd0, dout}, 32'(16'h0300 + k));
`endif
    end
    din_valid = 1'b0;
    tick();
`ifdef DATA_DEMUX_ERR_EN
    check("oor_err_clear", {31'd0, err}, 32'd0);
`endif
    check("oor_drained", {27'd0, dout_valid}, 32'd0);

    // Reset in the middle of a channel-1 packet
    beat(3'd1, 16'h0030, 1'b0);
    tick();
    beat(3'd1, 16'h0031, 1'b0);
    tick();
    check("mid_valid", {27'd0, dout_valid}, 32'h02);
    din_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("mid_rst_valid", {27'd0, dout_valid}, 32'd0);
    check("mid_rst_dout", {16'd0, dout}, 32'd0);
    check("mid_rst_last", {31'd0, dout_last}, 32'd0);
    check("mid_rst_ready", {31'd0, din_ready}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    beat(3'd3, 16'h0040, 1'b1);
    tick();
    check("post_rst_valid", {27'd0, dout_valid}, 32'h08);
    check("post_rst_dout", {16'd0, dout}, 32'h0040);
    din_valid = 1'b0;
    tick();
    check("post_rst_drained", {27'd0, dout_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/data_demux.md
DATA_DEMUX -- requirements
Module: data_demux

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 sel  input  3  destination channel 0..4, sampled only on the first beat of a packet.
REQ-005 din  input  WIDTH  input data word.
REQ-006 din_valid  input  1  input beat valid.
REQ-007 din_last  input  1  marks the final beat of the packet.
REQ-008 din_ready  output  1  block accepts the beat this cycle.
REQ-009 dout  output  WIDTH  registered data, shared by all channels.
REQ-010 dout_last  output  1  registered copy of din_last.
REQ-011 dout_valid  output  5  one-hot valid; bit n means dout is addressed to channel n.
REQ-012 dout_ready  input  5  per-channel ready from each consumer.
REQ-013 err  output  1  one-cycle pulse on a dropped packet; exists only with DATA_DEMUX_ERR_EN.

Function
REQ-014 A beat SHALL transfer in when din_valid && din_ready, and out on channel n when dout_valid[n] && dout_ready[n].
REQ-015 The block SHALL use one output register stage; latency from input acceptance to dout_valid is exactly 1 cycle.
REQ-016 din_ready SHALL equal !out_full || (dout_ready[ch] for the held channel ch), allowing back-to-back full-throughput transfer.
REQ-017 FSM states: IDLE (awaiting first beat), ROUTE (mid-packet), DROP (discarding; error build only).
REQ-018 In IDLE, an accepted beat with sel <= 4 SHALL latch ch = sel.
REQ-018a The FSM goes to ROUTE if din_last = 0, else stays in IDLE (single-beat packet).
REQ-019 In ROUTE, every accepted beat SHALL go to the latched ch regardless of sel; the beat with din_last = 1 returns the FSM to IDLE.
REQ-020 A sel change mid-packet SHALL have no effect.
REQ-021 The output register SHALL accept a new beat in the same cycle the held beat drains.
REQ-022 The output register SHALL hold dout, dout_last and dout_valid stable while the addressed dout_ready is low.
REQ-023 At most one dout_valid bit SHALL be set in any cycle; dout_ready bits of unaddressed channels SHALL be ignored.
REQ-024 A packet may end and the next packet may start in consecutive cycles with no idle cycle; the new sel is latched on that first beat.

Reset
REQ-025 While rst_n = 0, the block SHALL asynchronously force: FSM to IDLE, ch = 0, dout_valid = 5'b0, dout = 0, dout_last = 0, err = 0, din_ready = 0.
REQ-026 Reset mid-packet SHALL discard the held beat and the packet context; after reset the next accepted beat is treated as a first beat.
REQ-027 din_ready SHALL rise in the first cycle after rst_n deasserts.

Configuration
REQ-028 The macro DATA_DEMUX_ERR_EN SHALL select how an out-of-range sel (5..7) on a first beat is handled.
REQ-029 With DATA_DEMUX_ERR_EN defined, a first beat with sel > 4 SHALL:
- enter DROP, or stay in IDLE if it is a single-beat packet;
- pulse err for 1 cycle;
- hold din_ready = 1 and consume beats without output until the din_last beat, then return to IDLE.
REQ-030 With DATA_DEMUX_ERR_EN undefined, sel > 4 SHALL route the packet to channel 0, the err port and DROP state SHALL be absent, and there is no drop path.

Verification
REQ-031 Single beat: sel=3, din=16'hA5A5, din_last=1, dout_ready=5'b11111 -> next cycle dout_valid=5'b01000, dout=16'hA5A5, dout_last=1.
REQ-032 Packet stickiness: 4-beat packet 1,2,3,4 with sel=2 on beat 0 and sel=4 on beats 1..3 -> all beats on dout_valid[2] in order; dout_last on beat 4.
REQ-033 Backpressure: dout_ready[1]=0 for 5 cycles during a channel-1 packet -> dout held stable, din_ready=0 after one buffered beat, no loss or duplication; full rate resumes when ready returns.
REQ-034 Back-to-back packets: 1-beat packet with sel=0 immediately followed by a 2-beat packet with sel=4, always ready -> outputs on channels 0, 4, 4 in consecutive cycles, no bubble.
REQ-035 Out-of-range sel: 3-beat packet with sel=6 -> with DATA_DEMUX_ERR_EN: err pulses once, no dout_valid, 3 beats consumed; without it: 3 beats appear on channel 0.
REQ-036 Reset mid-packet: assert rst_n=0 after beat 2 of a sel=1 packet -> all outputs zero immediately; a new beat with sel=3 after release routes to channel 3.
